// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one fixed-latency memory between fetch and load/store.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall
);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic owner, last_owner, pend_if, pend_d, issue, sel_d, done;
  logic [DATA_WIDTH-1:0] hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // owner/last_owner: 1 = data, 0 = fetch; outputs are gated by rst_n so reset forces them quiet
  always_comb begin
    sel_d = d_req & (~if_req | ~last_owner);
    issue = rst_n & (state == IDLE) & (if_req | d_req);
    done = (state == BUSY) & (cnt == 4'(MEM_LATENCY));
    state_nxt = issue ? BUSY : done ? IDLE : state;
    if_gnt = issue & ~sel_d;
    d_gnt = issue & sel_d;
    mem_en = issue;
    mem_we = d_gnt & d_we;
    mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    mem_be = d_gnt ? d_be : {BW{if_gnt}};
    if_rvalid = done & ~owner;
    d_rvalid = done & owner;
    if_rdata = if_rvalid ? mem_rdata : hold;
    d_rdata = d_rvalid ? mem_rdata : hold;
    stall = rst_n & (((if_req | pend_if) & ~if_rvalid) | ((d_req | pend_d) & ~d_rvalid));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      owner <= 1'b0;
      last_owner <= 1'b0;
      pend_if <= 1'b0;
      pend_d <= 1'b0;
      hold <= '0;
    end else if (issue) begin
      cnt <= 4'd1;
      owner <= sel_d;
      last_owner <= sel_d;
      pend_if <= if_gnt;
      pend_d <= d_gnt;
    end else if (done) begin
      cnt <= '0;
      hold <= mem_rdata;
      pend_if <= 1'b0;
      pend_d <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt + 4'd1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (latency 2 and 1) against a transaction-level model and directed expectations.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req [2], d_req [2], d_we [2];
  logic [31:0] if_addr [2], d_addr [2], d_wdata [2];
  logic [3:0] d_be [2];
  logic if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2], mem_en [2], mem_we [2], stall [2];
  logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [3:0] mem_be [2];
  int cyc = 0, passed = 0, total = 0;
  logic [31:0] mem [int];
  int iss [2];
  logic [31:0] rword [2];
  logic s_en [2], s_we [2];
  logic [31:0] s_addr [2], s_wdata [2];
  logic [3:0] s_be [2];
  bit busy [2], own_d [2], st [2], last_d [2];
  int dl [2];
  logic [31:0] ew [2];
  logic m_done, m_want, m_wd, m_ig, m_dg, m_iv, m_dv, m_we, m_st, m_pi, m_pd;
  logic [31:0] m_ad, m_wdat;
  logic [3:0] m_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .d_req(d_req[0]), .d_we(d_we[0]),
    .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_be(d_be[0]), .d_gnt(d_gnt[0]),
    .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]),
    .mem_rdata(mem_rdata[0]), .stall(stall[0]));

  mem_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .d_req(d_req[1]), .d_we(d_we[1]),
    .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_be(d_be[1]), .d_gnt(d_gnt[1]),
    .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]),
    .mem_rdata(mem_rdata[1]), .stall(stall[1]));

  for (genvar g = 0; g < 2; g++) begin : g_proto
    a_if: assert property (@(posedge clk) disable iff (!rst_n) if_req[g] && !if_gnt[g] |=> if_req[g])
      else $error("protocol: fetch request dropped before grant");
    a_d: assert property (@(posedge clk) disable iff (!rst_n) d_req[g] && !d_gnt[g] |=> d_req[g])
      else $error("protocol: data request dropped before grant");
  end

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    int k;
    k = int'(a[31:2]);
    return mem.exists(k) ? mem[k] : {16'hC0DE, a[17:2]};
  endfunction

  function automatic void wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[int'(a[31:2])] = w;
  endfunction

  task automatic chk(input int i, input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL L%0d %s: got %h want %h (cycle %0d)", lat(i), n, a, e, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory emulation: requests are latched mid-cycle and serviced on the following edge.
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      s_en[i] = mem_en[i];
      s_we[i] = mem_we[i];
      s_addr[i] = mem_addr[i];
      s_wdata[i] = mem_wdata[i];
      s_be[i] = mem_be[i];
    end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++)
      if (s_en[i]) begin
        if (s_we[i]) wr(s_addr[i], s_wdata[i], s_be[i]);
        else rword[i] <= rd(s_addr[i]);
        iss[i] <= cyc;
      end
  end

  always_comb
    for (int i = 0; i < 2; i++)
      mem_rdata[i] = (cyc == iss[i] + lat(i)) ? rword[i] : (32'hBAD0_0000 ^ 32'(cyc));

  // Transaction model: one outstanding access with a completion deadline of issue cycle + latency.
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      {m_done, m_want, m_wd, m_ig, m_dg, m_iv, m_dv, m_we, m_st, m_pi, m_pd} = '0;
      m_ad = '0;
      m_wdat = '0;
      m_be = '0;
      if (rst_n) begin
        m_done = busy[i] && cyc == dl[i];
        m_iv = m_done && !own_d[i];
        m_dv = m_done && own_d[i];
        m_want = !busy[i] && (if_req[i] || d_req[i]);
        m_wd = d_req[i] && (!if_req[i] || !last_d[i]);
        m_dg = m_want && m_wd;
        m_ig = m_want && !m_wd;
        m_we = m_dg && d_we[i];
        m_ad = m_dg ? d_addr[i] : m_ig ? if_addr[i] : 32'h0;
        m_wdat = m_dg ? d_wdata[i] : 32'h0;
        m_be = m_dg ? d_be[i] : m_ig ? 4'hF : 4'h0;
        m_pi = busy[i] && !own_d[i];
        m_pd = busy[i] && own_d[i];
        m_st = ((if_req[i] || m_pi) && !m_iv) || ((d_req[i] || m_pd) && !m_dv);
      end
      chk(i, "if_gnt", 32'(if_gnt[i]), 32'(m_ig));
      chk(i, "d_gnt", 32'(d_gnt[i]), 32'(m_dg));
      chk(i, "if_rvalid", 32'(if_rvalid[i]), 32'(m_iv));
      chk(i, "d_rvalid", 32'(d_rvalid[i]), 32'(m_dv));
      chk(i, "mem_en", 32'(mem_en[i]), 32'(m_want));
      chk(i, "mem_we", 32'(mem_we[i]), 32'(m_we));
      chk(i, "mem_addr", mem_addr[i], m_ad);
      chk(i, "mem_wdata", mem_wdata[i], m_wdat);
      chk(i, "mem_be", 32'(mem_be[i]), 32'(m_be));
      chk(i, "stall", 32'(stall[i]), 32'(m_st));
      if (!rst_n) begin
        chk(i, "rst_if_rdata", if_rdata[i], 32'h0);
        chk(i, "rst_d_rdata", d_rdata[i], 32'h0);
        busy[i] = 1'b0;
        last_d[i] = 1'b0;
      end else begin
        if (m_iv) chk(i, "if_rdata", if_rdata[i], ew[i]);
        if (m_dv && !st[i]) chk(i, "d_rdata", d_rdata[i], ew[i]);
        if (m_done) busy[i] = 1'b0;
        if (m_want) begin
          busy[i] = 1'b1;
          own_d[i] = m_wd;
          st[i] = m_we;
          dl[i] = cyc + lat(i);
          ew[i] = rd(m_ad);
          last_d[i] = m_wd;
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      {if_req[i], d_req[i], d_we[i]} = '0;
      if_addr[i] = '0;
      d_addr[i] = '0;
      d_wdata[i] = '0;
      d_be[i] = '0;
      {s_en[i], s_we[i]} = '0;
      s_addr[i] = '0;
      s_wdata[i] = '0;
      s_be[i] = '0;
      iss[i] = -100;
      rword[i] = '0;
      {busy[i], own_d[i], st[i], last_d[i]} = '0;
      dl[i] = 0;
      ew[i] = '0;
    end
    mem[32'h100 >> 2] = 32'h1122_3344;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h40;
    d_req[0] = 1'b1;
    d_addr[0] = 32'h200;
    repeat (3) begin
      @(negedge clk);
      chk(0, "rst_d_gnt", 32'(d_gnt[0]), 0);
      chk(0, "rst_if_gnt", 32'(if_gnt[0]), 0);
      chk(0, "rst_stall", 32'(stall[0]), 0);
    end
    tick;
    rst_n = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick;
      if (k == 10) if_req[0] = 1'b0;
      @(negedge clk);
      chk(0, $sformatf("fair_d_gnt@%0d", k), 32'(d_gnt[0]), 32'(k % 6 == 0));
      chk(0, $sformatf("fair_if_gnt@%0d", k), 32'(if_gnt[0]), 32'(k % 6 == 3));
    end
    tick;
    d_req[0] = 1'b0;
    repeat (3) tick;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h10;
    @(negedge clk);
    chk(0, "fetch_gnt", 32'(if_gnt[0]), 1);
    chk(0, "fetch_mem_en", 32'(mem_en[0]), 1);
    chk(0, "fetch_addr", mem_addr[0], 32'h10);
    chk(0, "fetch_stall0", 32'(stall[0]), 1);
    tick;
    if_req[0] = 1'b0;
    @(negedge clk);
    chk(0, "fetch_stall1", 32'(stall[0]), 1);
    tick;
    @(negedge clk);
    chk(0, "fetch_rvalid", 32'(if_rvalid[0]), 1);
    chk(0, "fetch_rdata", if_rdata[0], 32'hC0DE_0004);
    chk(0, "fetch_stall2", 32'(stall[0]), 0);
    tick;
    d_req[0] = 1'b1;
    d_we[0] = 1'b1;
    d_addr[0] = 32'h100;
    d_wdata[0] = 32'hDEAD_BEEF;
    d_be[0] = 4'b0011;
    @(negedge clk);
    chk(0, "store_gnt", 32'(d_gnt[0]), 1);
    chk(0, "store_we", 32'(mem_we[0]), 1);
    chk(0, "store_be", 32'(mem_be[0]), 32'h3);
    chk(0, "store_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    tick;
    d_req[0] = 1'b0;
    tick;
    @(negedge clk);
    chk(0, "store_rvalid", 32'(d_rvalid[0]), 1);
    tick;
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    @(negedge clk);
    chk(0, "load_gnt", 32'(d_gnt[0]), 1);
    chk(0, "load_we", 32'(mem_we[0]), 0);
    tick;
    d_req[0] = 1'b0;
    tick;
    @(negedge clk);
    chk(0, "load_rvalid", 32'(d_rvalid[0]), 1);
    chk(0, "load_rdata", d_rdata[0], 32'h1122_BEEF);
    tick;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h20;
    @(negedge clk);
    chk(0, "abort_gnt", 32'(if_gnt[0]), 1);
    tick;
    if_req[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk(0, "abort_rvalid1", 32'(if_rvalid[0]), 0);
    tick;
    @(negedge clk);
    chk(0, "abort_rvalid2", 32'(if_rvalid[0]), 0);
    tick;
    rst_n = 1'b1;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h24;
    @(negedge clk);
    chk(0, "after_rst_gnt", 32'(if_gnt[0]), 1);
    tick;
    if_req[0] = 1'b0;
    tick;
    @(negedge clk);
    chk(0, "after_rst_rvalid", 32'(if_rvalid[0]), 1);
    chk(0, "after_rst_rdata", if_rdata[0], 32'hC0DE_0009);
    tick;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick;
      if_req[1] = 1'b1;
      if_addr[1] = 32'h80 + 32'(4 * ((k + 1) / 2));
      @(negedge clk);
      chk(1, $sformatf("l1_gnt@%0d", k), 32'(if_gnt[1]), 32'(k % 2 == 0));
      chk(1, $sformatf("l1_rvalid@%0d", k), 32'(if_rvalid[1]), 32'(k % 2 == 1));
      if (k >= 1) chk(1, $sformatf("l1_rdata@%0d", k), if_rdata[1], 32'hC0DE_0020 + 32'((k - 1) / 2));
    end
    tick;
    if_req[1] = 1'b0;
    @(negedge clk);
    chk(1, "l1_last_rvalid", 32'(if_rvalid[1]), 1);
    chk(1, "l1_last_rdata", if_rdata[1], 32'hC0DE_0024);
    tick;
    @(negedge clk);
    chk(1, "l1_hold_rdata", if_rdata[1], 32'hC0DE_0024);
    repeat (2) tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
